clk_div_monitor: RTL and testbench

- Checks the divided clock produced by the even clock divider, in the same `clk` domain that drives the divider.
- Samples the divided clock as data and measures its high-phase and low-phase durations in source `clk` cycles over NUM_PERIODS consecutive periods.
- Flags a pass/fail against an expected half-period, and times out if the divided clock stalls.
- Used as a self-check stage directly downstream of the divider, in bring-up and in the bench.

---
 rtl/clk_div_monitor_if.sv | 13 +
 rtl/clk_div_monitor.sv | 106 ++++++++++
 tb/tb_clk_div_monitor.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/clk_div_monitor_if.sv
// clk_div_monitor_if: divided-clock source/stimulus side (master) to monitor side (slave).
interface clk_div_monitor_if #(parameter int CNT_W = 16);
  logic div_in, start, busy, done, pass, timeout_err;
  logic [CNT_W-1:0] exp_half, high_cnt, low_cnt, period_cnt;
  modport master (
    output div_in, exp_half, start,
    input  busy, done, pass, timeout_err, high_cnt, low_cnt, period_cnt
  );
  modport slave (
    input  div_in, exp_half, start,
    output busy, done, pass, timeout_err, high_cnt, low_cnt, period_cnt
  );
endinterface

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures high/low phases of a divided clock over NUM_PERIODS periods.
// Define CLK_DIV_MON_SYNC_EN to add a two-flop synchroniser for an asynchronous div_in.
module clk_div_monitor #(
  parameter int CNT_W       = 16,
  parameter int NUM_PERIODS = 4,
  parameter int TIMEOUT     = 1024
) (
  input logic             clk,
  input logic             rst,
  clk_div_monitor_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ARM, MEAS_HIGH, MEAS_LOW, DONE} state_t;
  state_t state_q, state_d;
  logic div_src, div_s_q, div_p_q, rise, fall, any_edge, measuring, tmo, last;
  logic [CNT_W-1:0] exp_q, exp_d, hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic [CNT_W-1:0] high_q, high_d, low_q, low_d, period_q, period_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [7:0] per_q, per_d;
  logic mism_q, mism_d, pass_q, pass_d, tmo_err_q, tmo_err_d, busy_q, busy_d, done_q, done_d;
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
`ifdef CLK_DIV_MON_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else sync_q <= {sync_q[0], bus.div_in};
  assign div_src = sync_q[1];
`else
  assign div_src = bus.div_in;
`endif
  assign rise      = div_s_q & ~div_p_q;
  assign fall      = ~div_s_q & div_p_q;
  assign any_edge  = rise | fall;
  assign measuring = state_q inside {ARM, MEAS_HIGH, MEAS_LOW};
  assign tmo       = measuring & ~any_edge & (idle_q == TW'(TIMEOUT - 1));
  assign last      = per_q == 8'(NUM_PERIODS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (tmo) state_d = DONE;
    else
      case (state_q)
        IDLE, DONE: state_d = bus.start ? ARM : state_q;
        ARM:        state_d = rise ? MEAS_HIGH : ARM;
        MEAS_HIGH:  state_d = fall ? MEAS_LOW : MEAS_HIGH;
        MEAS_LOW:   state_d = rise ? (last ? DONE : MEAS_HIGH) : MEAS_LOW;
        default:    state_d = IDLE;
      endcase
  end
  always_comb begin
    exp_d = exp_q; hcnt_d = hcnt_q; lcnt_d = lcnt_q; idle_d = idle_q; per_d = per_q;
    mism_d = mism_q; high_d = high_q; low_d = low_q; period_d = period_q;
    pass_d = pass_q; tmo_err_d = tmo_err_q; busy_d = busy_q; done_d = 1'b0;
    if (!measuring && bus.start) begin
      exp_d = bus.exp_half; pass_d = 1'b0; tmo_err_d = 1'b0; per_d = '0;
      mism_d = 1'b0; idle_d = '0; busy_d = 1'b1;
    end else if (measuring) begin
      idle_d = any_edge ? '0 : idle_q + 1'b1;
      case (state_q)
        ARM: hcnt_d = rise ? CNT_W'(1) : hcnt_q;
        MEAS_HIGH:
          if (fall) begin
            high_d = hcnt_q;
            lcnt_d = CNT_W'(1);
          end else hcnt_d = sat(hcnt_q);
        MEAS_LOW:
          if (rise) begin
            low_d    = lcnt_q;
            period_d = high_q + lcnt_q;
            per_d    = per_q + 1'b1;
            mism_d   = mism_q | (high_q != exp_q) | (lcnt_q != exp_q) | (&high_q) | (&lcnt_q);
            hcnt_d   = CNT_W'(1);
          end else lcnt_d = sat(lcnt_q);
        default: ;
      endcase
      // timeout overrides any verdict reached in the same cycle
      if (state_d == DONE) begin
        tmo_err_d = tmo;
        pass_d    = ~mism_d & ~tmo;
        busy_d    = 1'b0;
        done_d    = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_s_q <= 1'b0; div_p_q <= 1'b0; exp_q <= '0; hcnt_q <= '0; lcnt_q <= '0;
      idle_q <= '0; per_q <= '0; mism_q <= 1'b0; high_q <= '0; low_q <= '0; period_q <= '0;
      pass_q <= 1'b0; tmo_err_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      div_s_q <= div_src; div_p_q <= div_s_q; exp_q <= exp_d; hcnt_q <= hcnt_d; lcnt_q <= lcnt_d;
      idle_q <= idle_d; per_q <= per_d; mism_q <= mism_d; high_q <= high_d; low_q <= low_d;
      period_q <= period_d; pass_q <= pass_d; tmo_err_q <= tmo_err_d; busy_q <= busy_d; done_q <= done_d;
    end
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.timeout_err = tmo_err_q;
  assign bus.high_cnt    = high_q;
  assign bus.low_cnt     = low_q;
  assign bus.period_cnt  = period_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: drives phase-list waveforms and checks results against a phase-list model.
module tb_clk_div_monitor;
  localparam int NP = 4;
  localparam int TO = 1024;
`ifdef CLK_DIV_MON_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  logic rst;
  int n_assert = 0;
  int n_fail = 0;
  int hs[NP];
  int ls[NP];
  clk_div_monitor_if #(.CNT_W(16)) bus ();
  clk_div_monitor #(.CNT_W(16), .NUM_PERIODS(NP), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] outs();
    return {bus.busy, bus.done, bus.pass, bus.timeout_err, bus.high_cnt, bus.low_cnt, bus.period_cnt};
  endfunction

  task automatic set_all(input int h, input int l);
    for (int k = 0; k < NP; k++) begin
      hs[k] = h;
      ls[k] = l;
    end
  endtask

  task automatic run(input string tag, input int pre, input logic [15:0] ex, input int restart_at, input int rst_at);
    bit wave[$];
    int ir, jd, nd;
    logic exp_pass;
    exp_pass = 1'b1;
    for (int i = 0; i < pre; i++) wave.push_back(1'b0);
    for (int k = 0; k < NP; k++) begin
      for (int i = 0; i < hs[k]; i++) wave.push_back(1'b1);
      for (int i = 0; i < ls[k]; i++) wave.push_back(1'b0);
      if (hs[k] != int'(ex) || ls[k] != int'(ex)) exp_pass = 1'b0;
    end
    ir = wave.size();
    repeat (3) wave.push_back(1'b1);
    repeat (8) wave.push_back(1'b0);
    jd = -1;
    nd = 0;
    for (int j = 0; j < wave.size(); j++) begin
      @(posedge clk);
      #1;
      bus.div_in   = wave[j];
      bus.start    = (j == 0 || j == restart_at);
      bus.exp_half = (j == 0) ? ex : ~ex;
      if (j == rst_at) rst = 1'b1;
      @(negedge clk);
      if (j == 1) chk({tag, " busy"}, bus.busy, 1'b1);
      if (bus.done) begin
        nd++;
        if (jd < 0) jd = j;
      end
      if (j == rst_at) begin
        chk({tag, " reset outs"}, outs(), 64'd0);
        rst = 1'b0;
        break;
      end
    end
    bus.start = 1'b0;
    bus.div_in = 1'b0;
    if (rst_at >= 0) begin
      chk({tag, " no done"}, nd, 0);
      repeat (8) @(posedge clk);
      return;
    end
    chk({tag, " done count"}, nd, 1);
    chk({tag, " done cycle"}, jd, ir + LAT);
    chk({tag, " pass"}, bus.pass, exp_pass);
    chk({tag, " timeout_err"}, bus.timeout_err, 1'b0);
    chk({tag, " high_cnt"}, bus.high_cnt, hs[NP-1]);
    chk({tag, " low_cnt"}, bus.low_cnt, ls[NP-1]);
    chk({tag, " period_cnt"}, bus.period_cnt, hs[NP-1] + ls[NP-1]);
    chk({tag, " busy end"}, bus.busy, 1'b0);
  endtask

  task automatic run_timeout();
    int jd, nd;
    jd = -1;
    nd = 0;
    for (int j = 0; j < TO + 20; j++) begin
      @(posedge clk);
      #1;
      bus.div_in = 1'b0;
      bus.start = (j == 0);
      bus.exp_half = 16'd2;
      @(negedge clk);
      if (bus.done) begin
        nd++;
        if (jd < 0) jd = j;
      end
    end
    bus.start = 1'b0;
    chk("tmo done count", nd, 1);
    chk("tmo done cycle", jd, TO + 1);
    chk("tmo timeout_err", bus.timeout_err, 1'b1);
    chk("tmo pass", bus.pass, 1'b0);
    chk("tmo busy", bus.busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.div_in = 1'b0;
    bus.start = 1'b0;
    bus.exp_half = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outs", outs(), 64'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    set_all(2, 2);
    run("div4", 2, 16'd2, -1, -1);
    set_all(3, 3);
    run("div6", 3, 16'd2, -1, -1);
    set_all(1, 1);
    run("div2", 1, 16'd1, -1, -1);
    set_all(2, 2);
    run("restart", 2, 16'd2, 6, -1);
    run("rst mid", 2, 16'd2, -1, 9 + LAT);
    run("fresh", 2, 16'd2, -1, -1);
    run_timeout();
    for (int r = 0; r < 8; r++) begin
      int ex;
      ex = $urandom_range(1, 6);
      for (int k = 0; k < NP; k++) begin
        hs[k] = (r % 2 == 0) ? ex : int'($urandom_range(1, 6));
        ls[k] = (r % 2 == 0) ? ex : int'($urandom_range(1, 6));
      end
      run($sformatf("rand%0d", r), $urandom_range(1, 4), 16'(ex), -1, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
